// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter.
// Fallback values for the core-wide sizing macros when no shared parameter header has been included.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef RF_DEPTH
`define RF_DEPTH 32
`endif
`ifndef RF_ADD_SIZE
`define RF_ADD_SIZE 5
`endif

package rf_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MEM  = 2'd2
    } wb_src_e;

    // The ALU stream has fixed priority and is never back-pressured; responses only fill idle slots.
    function automatic wb_src_e wb_select(input logic alu_sel, input logic q_empty);
        if (alu_sel)
            return WB_ALU;
        else if (!q_empty)
            return WB_MEM;
        else
            return WB_NONE;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_fifo.sv
// wb_fifo: synchronous FIFO with full/empty flags and same-cycle push/pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic          do_push, do_pop;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        do_push  = i_push & ~o_full;
        do_pop   = i_pop & ~o_empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the cleared count makes stale entries unreachable.
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_data;
    end

    assign o_data  = mem_q[rd_ptr_q];
    assign o_full  = (count_q == (PW+1)'(DEPTH));
    assign o_empty = (count_q == '0);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Merges ALU writebacks and queued load responses onto the register-file write port,
// and tracks pending loads for decode-stage RAW stalls.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int WIDTH  = `WIDTH,
    parameter int DEPTH  = `RF_DEPTH,
    parameter int ADDR   = `RF_ADD_SIZE,
    parameter int QDEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_alu_v,
    input  logic [ADDR-1:0]  i_alu_rd,
    input  logic [WIDTH-1:0] i_alu_data,
    input  logic             i_ld_issue,
    input  logic [ADDR-1:0]  i_ld_rd,
    input  logic             i_mem_v,
    output logic             o_mem_rdy,
    input  logic [ADDR-1:0]  i_mem_rd,
    input  logic [WIDTH-1:0] i_mem_data,
    output logic             o_w,
    output logic [ADDR-1:0]  o_dst,
    output logic [WIDTH-1:0] o_data,
    output logic [DEPTH-1:0] o_busy,
    output logic             o_err
);
    logic                  q_push, q_pop, q_full, q_empty;
    logic [ADDR+WIDTH-1:0] q_head;
    logic [ADDR-1:0]       head_rd;
    logic [WIDTH-1:0]      head_data;
    logic                  alu_sel, ld_set, viol;
    wb_src_e               src;

    logic                  w_q, w_d;
    logic [ADDR-1:0]       dst_q, dst_d;
    logic [WIDTH-1:0]      data_q, data_d;
    logic [DEPTH-1:0]      busy_q, busy_d;
    logic                  err_q, err_d;

    wb_fifo #(
        .W     (ADDR + WIDTH),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (q_push),
        .i_data  ({i_mem_rd, i_mem_data}),
        .i_pop   (q_pop),
        .o_data  (q_head),
        .o_full  (q_full),
        .o_empty (q_empty)
    );

    assign {head_rd, head_data} = q_head;

    always_comb begin
        alu_sel = i_alu_v & (i_alu_rd != '0);
        src     = wb_select(alu_sel, q_empty);
        q_pop   = (src == WB_MEM);
        q_push  = i_mem_v & ~q_full & (i_mem_rd != '0);

        w_d    = 1'b0;
        dst_d  = '0;
        data_d = '0;
        unique case (src)
            WB_ALU: begin
                w_d    = 1'b1;
                dst_d  = i_alu_rd;
                data_d = i_alu_data;
            end
            WB_MEM: begin
                w_d    = 1'b1;
                dst_d  = head_rd;
                data_d = head_data;
            end
            default: ;
        endcase

        // Set is applied after clear so a same-cycle re-issue keeps the register pending.
        ld_set = i_ld_issue & (i_ld_rd != '0);
        busy_d = busy_q;
        if (q_pop)  busy_d[head_rd] = 1'b0;
        if (ld_set) busy_d[i_ld_rd] = 1'b1;
        busy_d[0] = 1'b0;

        // Re-issuing to a register whose load retires this same cycle is legal.
        viol  = (ld_set & busy_q[i_ld_rd] & ~(q_pop & (head_rd == i_ld_rd)))
              | (alu_sel & busy_q[i_alu_rd])
              | (q_pop & ~busy_q[head_rd]);
        err_d = err_q | viol;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            w_q    <= 1'b0;
            dst_q  <= '0;
            data_q <= '0;
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            w_q    <= w_d;
            dst_q  <= dst_d;
            data_q <= data_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign o_mem_rdy = ~q_full;
    assign o_w       = w_q;
    assign o_dst     = dst_q;
    assign o_data    = data_q;
    assign o_busy    = busy_q;
    assign o_err     = err_q;

endmodule
